mem_access_ctrl: RTL and testbench

MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

---
 rtl/mem_access_ctrl_if.sv | 12 +
 rtl/mem_access_ctrl.sv | 90 +++++++++
 tb/tb_mem_access_ctrl.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_ctrl_if.sv
// mem_access_ctrl_if: CPU-side request/response bus of the SRAM access controller
interface mem_access_ctrl_if;
  logic        req;
  logic        we;
  logic [19:0] addr;
  logic [15:0] wdata;
  logic [15:0] rdata;
  logic        ack;
  logic        busy;
  modport master (output req, we, addr, wdata, input rdata, ack, busy);
  modport slave  (input req, we, addr, wdata, output rdata, ack, busy);
endinterface

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: single-word async SRAM access sequencer with one memory-mapped I/O word
module mem_access_ctrl #(
  parameter int          WAIT_CYCLES = 2,
  parameter logic [19:0] IO_ADDR     = 20'h0FFFF
) (
  input  logic                    clk,
  input  logic                    rst_n,
  mem_access_ctrl_if.slave        cpu,
  output logic [19:0]             sram_addr_o,
  output logic                    sram_ce_n_o,
  output logic                    sram_oe_n_o,
  output logic                    sram_we_n_o,
  output logic                    sram_ub_n_o,
  output logic                    sram_lb_n_o,
  input  logic [15:0]             sram_dq_in_i,
  output logic [15:0]             sram_dq_out_o,
  output logic                    sram_dq_oe_o,
  input  logic [15:0]             switches_i,
  output logic [15:0]             hex_out_o
);
  typedef enum logic [1:0] {IDLE, ACCESS, RECOVER, IO_DONE} state_t;
  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        we_q, we_d;
  logic [19:0] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d, rdata_q, rdata_d, hex_q, hex_d;
  logic        access;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    hex_d   = hex_q;
    case (state_q)
      IDLE: if (cpu.req) begin
        if (cpu.addr == IO_ADDR) begin
          state_d = IO_DONE;
          if (cpu.we) hex_d = cpu.wdata;
          else rdata_d = switches_i;
        end else begin
          state_d = ACCESS;
          addr_d  = cpu.addr;
          we_d    = cpu.we;
          wdata_d = cpu.wdata;
          cnt_d   = 4'(WAIT_CYCLES - 1);
        end
      end
      ACCESS: if (cnt_q == 4'd0) begin
        state_d = RECOVER;
        if (!we_q) rdata_d = sram_dq_in_i;
      end else cnt_d = cnt_q - 4'd1;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      hex_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      hex_q   <= hex_d;
    end
  end
  // Strobes decode straight from the state register so reset releases them without a clock
  assign access        = state_q == ACCESS;
  assign sram_ce_n_o   = !access;
  assign sram_ub_n_o   = !access;
  assign sram_lb_n_o   = !access;
  assign sram_oe_n_o   = !(access && !we_q);
  assign sram_we_n_o   = !(access && we_q);
  assign sram_dq_oe_o  = we_q && (access || state_q == RECOVER);
  assign sram_dq_out_o = wdata_q;
  assign sram_addr_o   = addr_q;
  assign hex_out_o     = hex_q;
  assign cpu.rdata     = rdata_q;
  assign cpu.ack       = state_q == RECOVER || state_q == IO_DONE;
  assign cpu.busy      = state_q != IDLE;
endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl: randomized checks of mem_access_ctrl against an SRAM model and a word-level reference memory
module tb_mem_access_ctrl;
  localparam int          W  = 2;
  localparam logic [19:0] IO = 20'h0FFFF;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  int tests = 0;
  int fails = 0;
  mem_access_ctrl_if bus();
  mem_access_ctrl_if bus1();
  mem_access_ctrl_if bus15();
  logic [19:0] sram_addr, a1, a15;
  logic        ce_n, oe_n, we_n, ub_n, lb_n, dq_oe, o1, o15;
  logic [15:0] dq_in, dq_out, switches, hex_out, dq_in1, dq_in15, d1, d15, h1, h15;
  logic [4:0]  s1, s15;
  logic [15:0] sram [1024];
  logic [15:0] ref_mem [1024];
  mem_access_ctrl #(.WAIT_CYCLES(W), .IO_ADDR(IO)) dut (
    .clk(clk), .rst_n(rst_n), .cpu(bus), .sram_addr_o(sram_addr),
    .sram_ce_n_o(ce_n), .sram_oe_n_o(oe_n), .sram_we_n_o(we_n), .sram_ub_n_o(ub_n), .sram_lb_n_o(lb_n),
    .sram_dq_in_i(dq_in), .sram_dq_out_o(dq_out), .sram_dq_oe_o(dq_oe),
    .switches_i(switches), .hex_out_o(hex_out));
  mem_access_ctrl #(.WAIT_CYCLES(1), .IO_ADDR(IO)) dut1 (
    .clk(clk), .rst_n(rst_n), .cpu(bus1), .sram_addr_o(a1),
    .sram_ce_n_o(s1[0]), .sram_oe_n_o(s1[1]), .sram_we_n_o(s1[2]), .sram_ub_n_o(s1[3]), .sram_lb_n_o(s1[4]),
    .sram_dq_in_i(dq_in1), .sram_dq_out_o(d1), .sram_dq_oe_o(o1),
    .switches_i(16'h0), .hex_out_o(h1));
  mem_access_ctrl #(.WAIT_CYCLES(15), .IO_ADDR(IO)) dut15 (
    .clk(clk), .rst_n(rst_n), .cpu(bus15), .sram_addr_o(a15),
    .sram_ce_n_o(s15[0]), .sram_oe_n_o(s15[1]), .sram_we_n_o(s15[2]), .sram_ub_n_o(s15[3]), .sram_lb_n_o(s15[4]),
    .sram_dq_in_i(dq_in15), .sram_dq_out_o(d15), .sram_dq_oe_o(o15),
    .switches_i(16'h0), .hex_out_o(h15));
  assign dq_in   = (!ce_n && !oe_n) ? sram[sram_addr[9:0]] : 16'hxxxx;
  assign dq_in1  = s1[1] ? 16'h0000 : 16'h1111;
  assign dq_in15 = s15[1] ? 16'h0000 : 16'h5555;
  // Async SRAM commits a write on the rising edge of we_n while data is still driven
  initial begin
    for (int i = 0; i < 1024; i++) sram[i] = 16'(i * 40503 + 7);
    sram[10'h123] = 16'hBEEF;
    forever begin
      @(posedge we_n);
      if (rst_n && dq_oe) sram[sram_addr[9:0]] = dq_out;
    end
  end
  task automatic xact(input logic w, input logic [19:0] a, input logic [15:0] d, input bit noise, output logic [15:0] rd);
    int lat = 1;
    int strb = 0;
    bit io = (a == IO);
    bus.req = 1'b1; bus.we = w; bus.addr = a; bus.wdata = d;
    @(posedge clk); #1;
    bus.req = 1'b0; bus.we = 1'($urandom); bus.addr = 20'($urandom); bus.wdata = 16'($urandom);
    while (!bus.ack && lat < 40) begin
      if (noise) bus.req = 1'($urandom);
      if (!oe_n || !we_n) strb++;
      tests++;
      if ({ce_n, oe_n, we_n, ub_n, lb_n, dq_oe, bus.busy} !== {1'b0, w, !w, 1'b0, 1'b0, w, 1'b1}) begin
        fails++;
        $display("FAIL access_strobes a=%h: got %b expected %b", a, {ce_n, oe_n, we_n, ub_n, lb_n, dq_oe, bus.busy}, {1'b0, w, !w, 1'b0, 1'b0, w, 1'b1});
      end
      tests++;
      if (sram_addr !== a || (w && dq_out !== d)) begin
        fails++;
        $display("FAIL access_bus: got addr %h data %h expected addr %h data %h", sram_addr, dq_out, a, d);
      end
      @(posedge clk); #1;
      lat++;
    end
    bus.req = 1'b0;
    tests++;
    if (lat != (io ? 1 : W + 1) || strb != (io ? 0 : W)) begin
      fails++;
      $display("FAIL latency a=%h: got ack at %0d strobes %0d expected %0d/%0d", a, lat, strb, io ? 1 : W + 1, io ? 0 : W);
    end
    tests++;
    if ({ce_n, oe_n, we_n, ub_n, lb_n, dq_oe, bus.busy} !== {5'b11111, w && !io, 1'b1}) begin
      fails++;
      $display("FAIL ack_strobes a=%h: got %b expected %b", a, {ce_n, oe_n, we_n, ub_n, lb_n, dq_oe, bus.busy}, {5'b11111, w && !io, 1'b1});
    end
    if (w && !io) begin
      tests++;
      if (dq_out !== d || sram_addr !== a) begin
        fails++;
        $display("FAIL data_hold: got %h@%h expected %h@%h", dq_out, sram_addr, d, a);
      end
    end
    rd = bus.rdata;
    @(posedge clk); #1;
    tests++;
    if ({bus.ack, bus.busy} !== 2'b00 || bus.rdata !== rd) begin
      fails++;
      $display("FAIL after_ack: got ack/busy %b rdata %h expected 00 rdata %h", {bus.ack, bus.busy}, bus.rdata, rd);
    end
  endtask
  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    tests++;
    if ({ce_n, oe_n, we_n, ub_n, lb_n, dq_oe, bus.ack, bus.busy} !== 8'b11111000 ||
        {bus.rdata, hex_out, sram_addr, dq_out} !== 68'h0) begin
      fails++;
      $display("FAIL reset_state: got %b %h %h %h %h", {ce_n, oe_n, we_n, ub_n, lb_n, dq_oe, bus.ack, bus.busy}, bus.rdata, hex_out, sram_addr, dq_out);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask
  task automatic test_read();
    logic [15:0] rd;
    xact(1'b0, 20'h00123, 16'h0, 1'b0, rd);
    tests++;
    if (rd !== 16'hBEEF) begin fails++; $display("FAIL read_beef: got %h expected BEEF", rd); end
  endtask
  task automatic test_write();
    logic [15:0] rd;
    xact(1'b1, 20'h00040, 16'h1234, 1'b0, rd);
    ref_mem[10'h040] = 16'h1234;
    xact(1'b0, 20'h00040, 16'h0, 1'b0, rd);
    tests++;
    if (rd !== 16'h1234) begin fails++; $display("FAIL write_readback: got %h expected 1234", rd); end
  endtask
  task automatic test_io();
    logic [15:0] rd;
    switches = 16'h00A5;
    xact(1'b0, IO, 16'h0, 1'b0, rd);
    tests++;
    if (rd !== 16'h00A5) begin fails++; $display("FAIL io_read: got %h expected 00A5", rd); end
    xact(1'b1, IO, 16'h7E57, 1'b0, rd);
    tests++;
    if (hex_out !== 16'h7E57 || bus.rdata !== 16'h00A5) begin
      fails++;
      $display("FAIL io_write: got hex %h rdata %h expected 7E57 00A5", hex_out, bus.rdata);
    end
  endtask
  task automatic test_random();
    logic [15:0] rd, d, exp, last_rd, last_hex;
    logic [19:0] a;
    logic w;
    bit io;
    last_rd = 16'h00A5;
    last_hex = 16'h7E57;
    for (int n = 0; n < 40; n++) begin
      w = 1'($urandom);
      io = $urandom_range(0, 5) == 0;
      a = io ? IO : 20'($urandom_range(0, 1023));
      d = 16'($urandom);
      switches = 16'($urandom);
      xact(w, a, d, 1'b1, rd);
      if (w) begin
        if (io) last_hex = d;
        else ref_mem[a[9:0]] = d;
        tests++;
        if (bus.rdata !== last_rd || hex_out !== last_hex) begin
          fails++;
          $display("FAIL rand_write a=%h: got rdata %h hex %h expected %h %h", a, bus.rdata, hex_out, last_rd, last_hex);
        end
      end else begin
        exp = io ? switches : ref_mem[a[9:0]];
        last_rd = exp;
        tests++;
        if (rd !== exp) begin fails++; $display("FAIL rand_read a=%h: got %h expected %h", a, rd, exp); end
      end
    end
  endtask
  task automatic test_back_to_back();
    logic [19:0] a;
    int acks = 0;
    bit exp_ack;
    a = 20'($urandom_range(0, 1023));
    bus.req = 1'b1; bus.we = 1'b0; bus.addr = a;
    for (int c = 1; c <= 3 * (W + 2); c++) begin
      @(posedge clk); #1;
      if (c == 3 * (W + 2) - 1) bus.req = 1'b0;
      exp_ack = (c % (W + 2)) == (W + 1);
      if (bus.ack) acks++;
      tests++;
      if (bus.ack !== exp_ack || bus.busy !== ((c % (W + 2)) != 0)) begin
        fails++;
        $display("FAIL b2b_cycle %0d: got ack %b busy %b expected %b %b", c, bus.ack, bus.busy, exp_ack, (c % (W + 2)) != 0);
      end
    end
    tests++;
    if (acks != 3 || bus.rdata !== ref_mem[a[9:0]]) begin
      fails++;
      $display("FAIL b2b_total: got %0d acks rdata %h expected 3 acks rdata %h", acks, bus.rdata, ref_mem[a[9:0]]);
    end
  endtask
  task automatic test_reset_mid_write();
    logic [19:0] a;
    logic [15:0] rd;
    a = 20'($urandom_range(0, 1023));
    bus.req = 1'b1; bus.we = 1'b1; bus.addr = a; bus.wdata = ~ref_mem[a[9:0]];
    @(posedge clk); #1;
    bus.req = 1'b0;
    @(posedge clk); #1;
    tests++;
    if (we_n !== 1'b0) begin fails++; $display("FAIL pre_abort: got we_n %b expected 0", we_n); end
    #2 rst_n = 1'b0;
    #1;
    tests++;
    if ({ce_n, oe_n, we_n, dq_oe, bus.ack, bus.busy} !== 6'b111000 || {bus.rdata, sram_addr, dq_out} !== 52'h0) begin
      fails++;
      $display("FAIL async_abort: got %b rdata %h addr %h dq %h", {ce_n, oe_n, we_n, dq_oe, bus.ack, bus.busy}, bus.rdata, sram_addr, dq_out);
    end
    repeat (2) begin
      @(posedge clk); #1;
      tests++;
      if (bus.ack !== 1'b0) begin fails++; $display("FAIL abort_ack: got %b expected 0", bus.ack); end
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    tests++;
    if (sram[a[9:0]] !== ref_mem[a[9:0]]) begin
      fails++;
      $display("FAIL abort_sram a=%h: got %h expected %h", a, sram[a[9:0]], ref_mem[a[9:0]]);
    end
    xact(1'b0, a, 16'h0, 1'b0, rd);
    tests++;
    if (rd !== ref_mem[a[9:0]]) begin fails++; $display("FAIL post_reset_read: got %h expected %h", rd, ref_mem[a[9:0]]); end
  endtask
  task automatic test_wait_builds();
    int lat;
    bus1.req = 1'b1; bus1.we = 1'b0; bus1.addr = 20'h5;
    @(posedge clk); #1;
    bus1.req = 1'b0;
    lat = 1;
    while (!bus1.ack && lat < 40) begin @(posedge clk); #1; lat++; end
    tests++;
    if (lat != 2 || bus1.rdata !== 16'h1111) begin
      fails++;
      $display("FAIL wait1: got latency %0d rdata %h expected 2 1111", lat, bus1.rdata);
    end
    bus15.req = 1'b1; bus15.we = 1'b0; bus15.addr = 20'h5;
    @(posedge clk); #1;
    bus15.req = 1'b0;
    lat = 1;
    while (!bus15.ack && lat < 40) begin @(posedge clk); #1; lat++; end
    tests++;
    if (lat != 16 || bus15.rdata !== 16'h5555) begin
      fails++;
      $display("FAIL wait15: got latency %0d rdata %h expected 16 5555", lat, bus15.rdata);
    end
  endtask
  initial begin
    bus.req = 1'b0;   bus.we = 1'b0;   bus.addr = '0;   bus.wdata = '0;
    bus1.req = 1'b0;  bus1.we = 1'b0;  bus1.addr = '0;  bus1.wdata = '0;
    bus15.req = 1'b0; bus15.we = 1'b0; bus15.addr = '0; bus15.wdata = '0;
    switches = '0;
    for (int i = 0; i < 1024; i++) ref_mem[i] = 16'(i * 40503 + 7);
    ref_mem[10'h123] = 16'hBEEF;
    test_reset();
    test_read();
    test_write();
    test_io();
    test_random();
    test_back_to_back();
    test_reset_mid_write();
    test_wait_builds();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
